// File: rtl/mul_seq_ctrl_pkg.sv
// Shared types and constants for the
// digit-serial multiplier sequencer.
package mul_seq_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int D   = 2;
  localparam int PPW = 4;

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Operand/product bundle plus the link
// to the external 2x2 multiplier.
interface mul_seq_ctrl_if #(
  parameter int N = 4
);
  logic           start;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic [1:0]     mul_a;
  logic [1:0]     mul_b;
  logic [3:0]     mul_p;
  logic           busy;
  logic           done;
  logic [2*N-1:0] p;

  modport master (
    output start, a, b, mul_p,
    input  mul_a, mul_b, busy, done, p
  );

  modport slave (
    input  start, a, b, mul_p,
    output mul_a, mul_b, busy, done, p
  );
endinterface

// File: rtl/mul_seq_idx.sv
// i/j digit-pair counter, j fastest;
// wrap flags the last pair (K-1,K-1).
module mul_seq_idx #(
  parameter  int K  = 2,
  localparam int IW = (K > 1) ? $clog2(K) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [IW-1:0] i_o,
  output logic [IW-1:0] j_o,
  output logic          wrap_o
);

  localparam logic [IW-1:0] LAST = IW'(K - 1);

  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;

  // next index: clear wins, else step
  always_comb begin
    i_d = i_q;
    j_d = j_q;
    if (clr_i) begin
      i_d = '0;
      j_d = '0;
    end else if (en_i) begin
      if (j_q == LAST) begin
        j_d = '0;
        i_d = (i_q == LAST) ? '0
                            : i_q + IW'(1);
      end else begin
        j_d = j_q + IW'(1);
      end
    end
  end

  // index registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q <= '0;
      j_q <= '0;
    end else begin
      i_q <= i_d;
      j_q <= j_d;
    end
  end

  assign i_o    = i_q;
  assign j_o    = j_q;
  assign wrap_o = (i_q == LAST) &&
                  (j_q == LAST);

endmodule

// File: rtl/mul_seq_ctrl.sv
// NxN multiply built from K*K passes
// through an external 2x2 multiplier.
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input logic           clk,
  input logic           rst,
  mul_seq_ctrl_if.slave bus
);

  localparam int K  = N / D;
  localparam int PW = 2 * N;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  state_e          state_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic [PW-1:0]   acc_q;
  logic [PW-1:0]   p_q;
  logic            busy_q;
  logic            done_q;

  logic [IW-1:0]   i;
  logic [IW-1:0]   j;
  logic            wrap;
  logic            accept;
  logic            run;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   sum;

  assign run    = (state_q == RUN);
  assign accept = !run && bus.start;

  mul_seq_idx #(.K(K)) u_idx (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (accept),
    .en_i   (run),
    .i_o    (i),
    .j_o    (j),
    .wrap_o (wrap)
  );

  // digit weight is 4^(i+j)
  assign pp  = PW'(bus.mul_p)
               << (D * (int'(i) + int'(j)));
  assign sum = acc_q + pp;

  assign bus.mul_a = run ? a_q[D*i +: D]
                         : '0;
  assign bus.mul_b = run ? b_q[D*j +: D]
                         : '0;

  // control FSM, operands and accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          acc_q <= sum;
          if (wrap) begin
            p_q     <= sum;
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.p    = p_q;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Scoreboard bench: expected products,
// digit pairs and done timing queued.
module tb_mul_seq_ctrl;

  localparam int N     = 4;
  localparam int K     = N / 2;
  localparam int STEPS = K * K;

  typedef struct {
    int due;
    int p;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   busy_cnt = 0;
  exp_t exp_q[$];
  int   exp_seq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_seq_ctrl_if #(.N(N)) bus ();

  mul_seq_ctrl #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mul_p = {2'b00, bus.mul_a} *
                     {2'b00, bus.mul_b};

  task automatic chk(string nm,
                     int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d",
               nm, act, exp);
    end
  endtask

  task automatic flag(string nm);
    checks++;
    errors++;
    $display("FAIL %s: got event want none",
             nm);
  endtask

  // monitor: compare whenever DUT shows data
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.busy) begin
        busy_cnt++;
        if (exp_seq.size() == 0) begin
          flag("digit_unexpected");
        end else begin
          chk("digit_pair",
              int'({bus.mul_a, bus.mul_b}),
              exp_seq.pop_front());
        end
      end
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          flag("done_unexpected");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("product", int'(bus.p), e.p);
          chk("done_cycle", cyc, e.due);
          chk("busy_len", busy_cnt, STEPS);
          chk("digits_idle",
              int'({bus.mul_a, bus.mul_b}), 0);
        end
        busy_cnt = 0;
      end
    end
  end

  // reference: plain multiply, base-4 digits
  task automatic push_op(int a, int b, int e);
    exp_t x;
    x.due = e + STEPS;
    x.p   = a * b;
    exp_q.push_back(x);
    for (int i = 0; i < K; i++)
      for (int j = 0; j < K; j++)
        exp_seq.push_back(
          ((a >> (2*i)) % 4) * 4 +
          ((b >> (2*j)) % 4));
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.busy && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: got busy want idle");
    end
  endtask

  task automatic run_op(int a, int b);
    wait_ready();
    bus.a     = N'(a);
    bus.b     = N'(b);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    push_op(a, b, cyc);
    bus.start = 1'b0;
  endtask

  initial begin
    int e1;
    int n;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  int'(bus.busy),  0);
    chk("rst_done",  int'(bus.done),  0);
    chk("rst_p",     int'(bus.p),     0);
    chk("rst_mul_a", int'(bus.mul_a), 0);
    chk("rst_mul_b", int'(bus.mul_b), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(15, 15);
    run_op(6, 9);
    run_op(0, 13);
    run_op(13, 1);

    run_op(5, 7);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.a     = 4'd15;
    bus.b     = 4'd15;
    repeat (2) @(posedge clk);
    #1;
    bus.start = 1'b0;

    run_op(11, 3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy",  int'(bus.busy),  0);
    chk("arst_done",  int'(bus.done),  0);
    chk("arst_p",     int'(bus.p),     0);
    chk("arst_mul_a", int'(bus.mul_a), 0);
    chk("arst_mul_b", int'(bus.mul_b), 0);
    exp_q.delete();
    exp_seq.delete();
    busy_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    run_op(11, 3);

    wait_ready();
    bus.a     = 4'd9;
    bus.b     = 4'd10;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    e1 = cyc;
    push_op(9, 10, e1);
    bus.a = 4'd3;
    bus.b = 4'd14;
    repeat (STEPS + 1) @(posedge clk);
    #1;
    push_op(3, 14, cyc);
    bus.start = 1'b0;

    for (int t = 0; t < 24; t++) begin
      repeat ($urandom_range(0, 3))
        @(posedge clk);
      #1;
      run_op(int'($urandom_range(0, 15)),
             int'($urandom_range(0, 15)));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_results", exp_q.size(), 0);
    chk("drain_digits", exp_seq.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
